// File: rtl/router_1xn_top.sv
// -----------------------------------------------------------------------------
// router_1xn_top
//
// Purpose:
//   1xN packet router. One byte stream comes in and is steered to one of
//   NUM_PORTS output FIFOs by the 2-bit address in the packet header.
//   Packet layout: header {len[DATA_W-1:2], addr[1:0]}, len payload bytes,
//   then one parity byte, which is the XOR of the header and every payload byte.
//   Packets with addr >= NUM_PORTS are consumed and discarded. An output FIFO
//   that holds data nobody reads for TIMEOUT cycles is flushed. A flush that
//   hits the packet currently being loaded aborts that packet.
//
// Optional feature (macro LEN_CHECK_EN):
//   When defined, the payload count is compared against the header length and
//   a mismatch also raises err. When undefined, the count logic is not built
//   and err reports parity errors only.
//
// Parameters:
//   NUM_PORTS  : output channels, 2..4 (the address field is fixed at 2 bits)
//   DATA_W     : byte width, >= 4 (the length field is DATA_W-2 bits)
//   FIFO_DEPTH : words per output FIFO, power of 2, >= 4
//   TIMEOUT    : cycles a non-empty, unread FIFO waits before it is flushed, >= 2
//
// Ports:
//   clock       in   single clock; all state changes on the rising edge
//   resetn      in   asynchronous, active-low reset
//   pkt_valid   in   high for header and payload bytes, low for the parity byte
//   data_in     in   input byte
//   read_enb    in   per-port read request
//   busy        out  input byte not accepted this cycle
//   err         out  parity (and optional length) error of last completed packet
//   pkt_drop    out  one-cycle pulse after a packet's final byte is discarded
//   vld_out     out  FIFO i not empty
//   soft_rst    out  one-cycle pulse after FIFO i is flushed by timeout
//   data_out    out  port i data at [i*DATA_W +: DATA_W]
//   dbg_state_o out  current FSM state, for observation only
//
// Input handshake:
//   The source presents data_in/pkt_valid and holds them while busy is high.
//   A byte is consumed at a rising edge when busy is low and the FSM is in a
//   state that takes bytes: DECODE with pkt_valid high (header), LOAD_DATA
//   (payload or parity), or DROP (discarded byte). In DECODE, a cycle with
//   pkt_valid low is idle and consumes nothing.
// -----------------------------------------------------------------------------
module router_1xn_top #(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          pkt_valid,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [NUM_PORTS-1:0]          read_enb,
    output logic                          busy,
    output logic                          err,
    output logic                          pkt_drop,
    output logic [NUM_PORTS-1:0]          vld_out,
    output logic [NUM_PORTS-1:0]          soft_rst,
    output logic [NUM_PORTS*DATA_W-1:0]   data_out,
    output logic [2:0]                    dbg_state_o
);

    localparam int           AW       = $clog2(FIFO_DEPTH);
    localparam int           TW       = $clog2(TIMEOUT);
    localparam int           LEN_W    = DATA_W - 2;
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]   NP       = 3'(NUM_PORTS);

    typedef enum logic [2:0] {
        S_DECODE     = 3'd0,
        S_WAIT_EMPTY = 3'd1,
        S_LOAD_HDR   = 3'd2,
        S_LOAD_DATA  = 3'd3,
        S_CHECK      = 3'd4,
        S_DROP       = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hdr_q, hdr_d;
    logic [DATA_W-1:0]   par_q, par_d;        // running XOR of header + payload
    logic [DATA_W-1:0]   rx_par_q, rx_par_d;  // parity byte as received
    logic                err_q, err_d;
    logic                drop_q, drop_d;

    // Per-port FIFO status and control
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_flush;
    logic [NUM_PORTS-1:0] fifo_wr;
    logic                 wr_en;
    logic [DATA_W-1:0]    wr_data;

    // Status of the FIFO addressed by the incoming byte (DECODE) and by the
    // latched header (all later states).
    logic hdr_sel_empty;
    logic tgt_empty;
    logic tgt_full;
    logic tgt_flush;
    logic hdr_addr_ok;
    logic busy_c;

`ifdef LEN_CHECK_EN
    logic [LEN_W-1:0] cnt_q, cnt_d;
`endif

    assign hdr_addr_ok = ({1'b0, data_in[1:0]} < NP);

    always_comb begin
        hdr_sel_empty = 1'b0;
        tgt_empty     = 1'b0;
        tgt_full      = 1'b0;
        tgt_flush     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_in[1:0] == 2'(i)) begin
                hdr_sel_empty = fifo_empty[i];
            end
            if (hdr_q[1:0] == 2'(i)) begin
                tgt_empty = fifo_empty[i];
                tgt_full  = fifo_full[i];
                tgt_flush = fifo_flush[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        par_d    = par_q;
        rx_par_d = rx_par_q;
        err_d    = err_q;
        drop_d   = 1'b0;
        busy_c   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = data_in;
`ifdef LEN_CHECK_EN
        cnt_d    = cnt_q;
`endif

        unique case (state_q)
            S_DECODE: begin
                if (pkt_valid) begin
                    hdr_d = data_in;
                    par_d = data_in;
                    err_d = 1'b0;
`ifdef LEN_CHECK_EN
                    cnt_d = '0;
`endif
                    if (!hdr_addr_ok) begin
                        state_d = S_DROP;
                    end else if (hdr_sel_empty) begin
                        state_d = S_LOAD_HDR;
                    end else begin
                        state_d = S_WAIT_EMPTY;
                    end
                end
            end

            S_WAIT_EMPTY: begin
                busy_c = 1'b1;
                if (tgt_empty) begin
                    state_d = S_LOAD_HDR;
                end
            end

            S_LOAD_HDR: begin
                busy_c = 1'b1;
                if (tgt_flush) begin
                    state_d = S_DROP;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = hdr_q;
                    state_d = S_LOAD_DATA;
                end
            end

            S_LOAD_DATA: begin
                busy_c = tgt_full;
                if (tgt_full) begin
                    // Byte not taken; if the FIFO is flushed now, the rest of
                    // the packet (including this held byte) is dropped.
                    if (tgt_flush) begin
                        state_d = S_DROP;
                    end
                end else if (tgt_flush) begin
                    // Byte is consumed but discarded. If it was the parity
                    // byte the packet is over here, so return straight to
                    // DECODE instead of waiting in DROP for a byte that will
                    // never come.
                    if (pkt_valid) begin
                        state_d = S_DROP;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_DECODE;
                    end
                end else if (pkt_valid) begin
                    wr_en = 1'b1;
                    par_d = par_q ^ data_in;
`ifdef LEN_CHECK_EN
                    cnt_d = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
`endif
                end else begin
                    wr_en    = 1'b1;
                    rx_par_d = data_in;
                    state_d  = S_CHECK;
                end
            end

            S_CHECK: begin
                busy_c = 1'b1;
`ifdef LEN_CHECK_EN
                err_d  = (par_q != rx_par_q) || (cnt_q != hdr_q[DATA_W-1:2]);
`else
                err_d  = (par_q != rx_par_q);
`endif
                state_d = S_DECODE;
            end

            S_DROP: begin
                if (!pkt_valid) begin
                    drop_d  = 1'b1;
                    state_d = S_DECODE;
                end
            end

            default: begin
                state_d = S_DECODE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_DECODE;
            hdr_q    <= '0;
            par_q    <= '0;
            rx_par_q <= '0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            par_q    <= par_d;
            rx_par_q <= rx_par_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

`ifdef LEN_CHECK_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign busy        = busy_c;
    assign err         = err_q;
    assign pkt_drop    = drop_q;
    assign dbg_state_o = state_q;

    // -------------------------------------------------------------------------
    // Output FIFOs with per-port read-timeout flush
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]     wr_ptr_q;
        logic [AW-1:0]     rd_ptr_q;
        logic [AW:0]       count_q;     // extra bit separates full from empty
        logic [TW-1:0]     tcnt_q;
        logic [DATA_W-1:0] dout_q;
        logic              srst_q;
        logic              do_wr;
        logic              do_rd;

        assign fifo_wr[g]    = wr_en && (hdr_q[1:0] == 2'(g));
        assign fifo_empty[g] = (count_q == '0);
        assign fifo_full[g]  = (count_q == FULL_CNT);
        // Flush fires on the TIMEOUT-th consecutive edge with data waiting and
        // no read; it can therefore never coincide with a read.
        assign fifo_flush[g] = !fifo_empty[g] && !read_enb[g] && (tcnt_q == TO_LAST);

        // Full blocks a write even when a read frees a slot the same edge.
        assign do_wr = fifo_wr[g] && !fifo_full[g] && !fifo_flush[g];
        assign do_rd = read_enb[g] && !fifo_empty[g];

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                tcnt_q   <= '0;
                dout_q   <= '0;
                srst_q   <= 1'b0;
            end else begin
                srst_q <= fifo_flush[g];
                if (fifo_flush[g]) begin
                    // data_out deliberately keeps its last value
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    tcnt_q   <= '0;
                end else begin
                    if (do_wr) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (do_rd) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        dout_q   <= mem[rd_ptr_q];
                    end
                    unique case ({do_wr, do_rd})
                        2'b10:   count_q <= count_q + 1'b1;
                        2'b01:   count_q <= count_q - 1'b1;
                        default: count_q <= count_q;
                    endcase
                    if (fifo_empty[g] || read_enb[g]) begin
                        tcnt_q <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
            end
        end

        // Storage needs no reset: a word is only ever read after it is written.
        always_ff @(posedge clock) begin
            if (do_wr) begin
                mem[wr_ptr_q] <= wr_data;
            end
        end

        assign vld_out[g]                    = !fifo_empty[g];
        assign soft_rst[g]                   = srst_q;
        assign data_out[g*DATA_W +: DATA_W]  = dout_q;
    end

endmodule
